// File: rtl/inst_feeder_pkg.sv
// Shared definitions for the instruction feeder: op encodings, NOP word and FSM states.
package inst_feeder_pkg;

    // Two-bit op field, instruction bits [7:6]
    localparam logic [1:0] OpNop = 2'b00;
    localparam logic [1:0] OpAdd = 2'b01;
    localparam logic [1:0] OpSub = 2'b10;
    localparam logic [1:0] OpAnd = 2'b11;

    localparam logic [7:0] NopWord = {OpNop, 6'b00_00_00};

    typedef enum logic [1:0] {
        FsmIdle  = 2'd0,
        FsmRun   = 2'd1,
        FsmDrain = 2'd2,
        FsmDone  = 2'd3
    } fsm_state_e;

    // Plain-vector state codes so the state register stays a logic vector
    localparam logic [1:0] StIdle  = FsmIdle;
    localparam logic [1:0] StRun   = FsmRun;
    localparam logic [1:0] StDrain = FsmDrain;
    localparam logic [1:0] StDone  = FsmDone;

    // Increment that sticks at all-ones
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/inst_feeder_if.sv
// Load/control/issue bundle between a program loader and the instruction feeder.
interface inst_feeder_if #(
    parameter int unsigned DEPTH = 16
) ();
    localparam int unsigned AW = $clog2(DEPTH);

    logic          load_valid;
    logic          load_ready;
    logic [7:0]    load_inst;
    logic          clr;
    logic          start;
    logic          abort;
    logic [7:0]    inst;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
    logic [AW:0]   prog_len;
    logic [7:0]    issued_cnt;

    modport master (
        output load_valid, load_inst, clr, start, abort,
        input  load_ready, inst, busy, done, pc, prog_len, issued_cnt
    );

    modport slave (
        input  load_valid, load_inst, clr, start, abort,
        output load_ready, inst, busy, done, pc, prog_len, issued_cnt
    );

endinterface

// File: rtl/inst_mem.sv
// Program buffer: synchronous write, asynchronous read, no reset on the array.
module inst_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_feeder.sv
// Instruction feeder: buffers a short program, then issues it one word per cycle
// followed by drain NOPs so the back end of the pipeline can retire.
module inst_feeder
    import inst_feeder_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    inst_feeder_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [LW-1:0] FullLen   = LW'(DEPTH);
    localparam logic [DW-1:0] DrainLast = DW'(DRAIN_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    issued_q, issued_d;
    logic [7:0]    inst_q, inst_d;
    logic [DW-1:0] drain_q, drain_d;

    logic          load_ready;
    logic          load_fire;
    logic          last_word;
    logic [7:0]    rd_data;

    // clr blocks acceptance so it wins over a simultaneous load
    assign load_ready = (state_q == StIdle) && (len_q < FullLen) && !bus.clr;
    assign load_fire  = bus.load_valid && load_ready;
    assign last_word  = ({1'b0, pc_q} == (len_q - LW'(1)));

    inst_mem #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_mem (
        .clk   (clk),
        .we    (load_fire),
        .waddr (len_q[AW-1:0]),
        .wdata (bus.load_inst),
        .raddr (pc_q),
        .rdata (rd_data)
    );

    // Next-state logic for the issue FSM and its counters
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        issued_d = issued_q;
        inst_d   = NopWord;
        drain_d  = drain_q;

        case (state_q)
            StIdle: begin
                if (bus.clr) begin
                    len_d = '0;
                end else begin
                    if (load_fire) begin
                        len_d = len_q + LW'(1);
                    end
                    if (bus.start && (len_q != '0)) begin
                        state_d  = StRun;
                        pc_d     = '0;
                        issued_d = '0;
                    end
                end
            end
            StRun: begin
                if (bus.abort) begin
                    // Suppressed issue: NOP goes out, pc holds
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    inst_d   = rd_data;
                    issued_d = sat_inc8(issued_q);
                    if (last_word) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; the buffer length resets but the array contents do not
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            len_q    <= '0;
            issued_q <= '0;
            inst_q   <= NopWord;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            inst_q   <= inst_d;
            drain_q  <= drain_d;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.inst       = inst_q;
    assign bus.busy       = (state_q == StRun) || (state_q == StDrain);
    assign bus.done       = (state_q == StDone);
    assign bus.pc         = pc_q;
    assign bus.prog_len   = len_q;
    assign bus.issued_cnt = issued_q;

endmodule
